serial_tx: RTL and testbench
============================

Name: serial_tx

Overview:
- Laser-link serial transmitter; sits directly upstream of serial_rx across the optical link.
- Takes a PKT_LENGTH-bit word via a valid/ready handshake and drives it onto tx.
- Frame: line idles low; one high start bit; PKT_LENGTH data bits, LSB first; at least GAP_BITS bit-times of low.
- Each bit lasts CLK_PER_BIT clocks. serial_rx decodes this frame without modification.

Parameters:
- CLK_PER_BIT, 50: clocks per bit period; must be >= 2.
- PKT_LENGTH, 32: data bits per frame; must be >= 1.
- GAP_BITS, 2: minimum low bit-times after the last data bit; must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- data  in  PKT_LENGTH  word to send; sampled only on acceptance.
- new_data  in  1  data valid.
- ready  out  1  block can accept a word this cycle.
- tx  out  1  registered serial line output to the laser driver.
- busy  out  1  high while a frame (start, data or gap) is in progress.

Behaviour:
- Reset values: tx=0, busy=0, ready=1, state=IDLE, counters=0. Any buffered word is discarded.
- Acceptance: the word is accepted on a rising edge where new_data && ready. data is captured into the shift register. It is never sampled again.
- States:
  - IDLE: tx=0, ready=1. On acceptance -> START, ctr=0, bit_ctr=0.
  - START: tx=1 for exactly CLK_PER_BIT cycles, then -> DATA.
  - DATA: tx=shift[0] for CLK_PER_BIT cycles. Then shift right, bit_ctr++. After bit PKT_LENGTH-1 -> GAP.
  - GAP: tx=0 for GAP_BITS*CLK_PER_BIT cycles, then -> IDLE.
- Counters:
  - ctr width is $clog2(CLK_PER_BIT); it wraps at CLK_PER_BIT-1.
  - bit_ctr width is $clog2(PKT_LENGTH+1).
  - The gap counter counts bit-times with the same ctr, using width $clog2(GAP_BITS+1).
- Latency: tx rises on the first edge after the accept edge. The start bit occupies cycles 1..CLK_PER_BIT after acceptance.
- Frame period: (1+PKT_LENGTH+GAP_BITS)*CLK_PER_BIT cycles from acceptance to ready=1 again. With new_data held high, frames repeat at exactly this period plus 1 IDLE cycle.
- Outputs: busy = (state != IDLE). ready = (state == IDLE) when the optional feature is off.
- No glitches on tx: it is driven only from a flop.
- new_data while not ready: ignored. The upstream must hold data until ready.
- rst mid-frame: tx is forced low on the next edge. The truncated frame is lost, and serial_rx resynchronises after the line has been low.
- Illegal or unused state encoding: -> IDLE with tx=0.

Optional Feature:
- Macro: SERIAL_TX_BUF_EN.
- When defined:
  - A one-word holding buffer is added, and ready = !buf_valid.
  - A word accepted while busy goes to the buffer.
  - At the end of GAP with buf_valid=1, the FSM goes straight to START (no IDLE cycle) and the buffer loads the shift register. Back-to-back period is then exactly (1+PKT_LENGTH+GAP_BITS)*CLK_PER_BIT.
  - A word accepted in IDLE with the buffer empty goes directly to the shift register.
- When undefined: no buffer; ready = (state == IDLE).

Decomposition:
- Package lasernet_serial_pkg holds:
  - the FSM state enum (IDLE, START, DATA, GAP);
  - default CLK_PER_BIT and PKT_LENGTH;
  - line levels LINE_IDLE=0 and LINE_START=1, shared with serial_rx.
- One sub-module is natural: serial_bit_timer. It is a CLK_PER_BIT counter with clear and enable inputs and a one-cycle bit_done pulse.

Test Plan:
- Frame shape, CLK_PER_BIT=4, PKT_LENGTH=8, GAP_BITS=2; send 8'hA5:
  - tx=1 for 4 cycles;
  - then bits 1,0,1,0,0,1,0,1 at 4 cycles each;
  - then tx=0 for 8 cycles;
  - ready reasserts at cycle 44.
- Back-to-back: hold new_data=1 with 8'hFF then 8'h00. Second start bit begins 45 cycles after the first (45 with the buffer feature off, 44 with it on). tx is low for the full gap between the frames.
- Handshake: pulse new_data while busy, feature off -> the word is ignored, tx is unaffected, ready=0 throughout.
- Reset mid-frame: assert rst during bit 3 of 8'hFF -> tx=0, busy=0 and ready=1 on the next edge. A new send afterwards produces a clean frame.
- Loopback at defaults (50, 32, 2): tx feeds serial_rx. Send 32'hDEADBEEF, 32'h00000001, 32'h80000000 -> serial_rx asserts new_data once per frame with matching data and no extra frames.

Source files
------------

// File: rtl/lasernet_serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lasernet_serial_pkg
//  Purpose  : Shared definitions for the laser-link serial transmitter and
//             its matching receiver (serial_rx): transmitter FSM state
//             encoding, default frame geometry and line levels.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package lasernet_serial_pkg;

    // Default frame geometry
    localparam int DEF_CLK_PER_BIT = 50;
    localparam int DEF_PKT_LENGTH  = 32;
    localparam int DEF_GAP_BITS    = 2;

    // Line levels; the receiver keys on the idle->start transition
    localparam logic LINE_IDLE  = 1'b0;
    localparam logic LINE_START = 1'b1;

    // Transmitter frame state
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        GAP   = 2'd3
    } tx_state_e;

endpackage : lasernet_serial_pkg
`default_nettype wire

// File: rtl/serial_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module   : serial_bit_timer
//  Purpose  : Bit-period timer. Counts 0..CLK_PER_BIT-1 while enabled and
//             pulses bit_done for one cycle on the last clock of each bit
//             period, then wraps to 0.
//  Ports    : clk      in   clock
//             rst      in   synchronous reset, active-high
//             clear    in   force the count to 0 (priority over en)
//             en       in   advance the count
//             bit_done out  high on the final cycle of a bit period
//  Revision : 1.0  initial release
// ============================================================================
module serial_bit_timer #(
    parameter int CLK_PER_BIT = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic bit_done
);

    localparam int              CTR_W    = $clog2(CLK_PER_BIT);
    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(CLK_PER_BIT - 1);

    logic [CTR_W-1:0] ctr_q;
    logic [CTR_W-1:0] ctr_d;

    always_comb begin
        ctr_d = ctr_q;
        if (clear) begin
            ctr_d = '0;
        end else if (en) begin
            if (ctr_q == CTR_LAST) begin
                ctr_d = '0;
            end else begin
                ctr_d = ctr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctr_q <= '0;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign bit_done = en && (ctr_q == CTR_LAST);

endmodule : serial_bit_timer
`default_nettype wire

// File: rtl/serial_tx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx
//  Purpose  : Laser-link serial transmitter. Accepts a PKT_LENGTH-bit word
//             over a valid/ready handshake and sends it as a frame:
//             one high start bit, PKT_LENGTH data bits LSB first, then at
//             least GAP_BITS low bit-times. Each bit lasts CLK_PER_BIT clocks.
//             The line idles low and is driven only from a flop.
//  Build    : SERIAL_TX_BUF_EN adds a one-word holding buffer so frames can
//             run back-to-back with no idle cycle between them.
//  Ports    : clk       in   clock
//             rst       in   synchronous reset, active-high
//             data      in   [PKT_LENGTH] word, sampled only on acceptance
//             new_data  in   data valid
//             ready     out  a word can be accepted this cycle
//             tx        out  registered serial line
//             busy      out  a frame (start, data or gap) is in progress
//  Revision : 1.0  initial release
// ============================================================================
module serial_tx
    import lasernet_serial_pkg::*;
#(
    parameter int CLK_PER_BIT = DEF_CLK_PER_BIT,
    parameter int PKT_LENGTH  = DEF_PKT_LENGTH,
    parameter int GAP_BITS    = DEF_GAP_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PKT_LENGTH-1:0] data,
    input  logic                  new_data,
    output logic                  ready,
    output logic                  tx,
    output logic                  busy
);

    localparam int               BIT_W    = $clog2(PKT_LENGTH + 1);
    localparam int               GAP_W    = $clog2(GAP_BITS + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PKT_LENGTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BITS - 1);

    tx_state_e             state_q;
    tx_state_e             state_d;
    logic [PKT_LENGTH-1:0] shift_q;
    logic [PKT_LENGTH-1:0] shift_d;
    logic [BIT_W-1:0]      bit_ctr_q;
    logic [BIT_W-1:0]      bit_ctr_d;
    logic [GAP_W-1:0]      gap_ctr_q;
    logic [GAP_W-1:0]      gap_ctr_d;
    logic                  tx_q;
    logic                  tx_d;

    logic                  accept;
    logic                  bit_done;
    logic                  timer_clear;
    logic                  timer_en;

`ifdef SERIAL_TX_BUF_EN
    logic [PKT_LENGTH-1:0] buf_q;
    logic [PKT_LENGTH-1:0] buf_d;
    logic                  buf_valid_q;
    logic                  buf_valid_d;
    // Set when the accepted word goes straight into the shift register
    // rather than into the holding buffer.
    logic                  load_direct;

    assign ready = !buf_valid_q;
`else
    assign ready = (state_q == IDLE);
`endif

    assign accept = new_data && ready;
    assign busy   = (state_q != IDLE);
    assign tx     = tx_q;

    // The timer sits at zero while idle, so the first frame bit always
    // starts a full period. Between back-to-back frames it simply wraps.
    assign timer_clear = (state_q == IDLE);
    assign timer_en    = (state_q != IDLE);

    serial_bit_timer #(
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear),
        .en       (timer_en),
        .bit_done (bit_done)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_ctr_d = bit_ctr_q;
        gap_ctr_d = gap_ctr_q;
`ifdef SERIAL_TX_BUF_EN
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        load_direct = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = START;
                    shift_d   = data;
                    bit_ctr_d = '0;
                    gap_ctr_d = '0;
`ifdef SERIAL_TX_BUF_EN
                    load_direct = 1'b1;
`endif
                end
            end

            START: begin
                if (bit_done) begin
                    state_d = DATA;
                end
            end

            DATA: begin
                if (bit_done) begin
                    shift_d   = shift_q >> 1;
                    bit_ctr_d = bit_ctr_q + 1'b1;
                    if (bit_ctr_q == BIT_LAST) begin
                        state_d   = GAP;
                        gap_ctr_d = '0;
                    end
                end
            end

            GAP: begin
                if (bit_done) begin
                    if (gap_ctr_q == GAP_LAST) begin
                        state_d   = IDLE;
                        gap_ctr_d = '0;
`ifdef SERIAL_TX_BUF_EN
                        // Chain straight into the next frame. A word
                        // arriving on this very edge (buffer empty) is
                        // also taken directly, otherwise it would sit in
                        // the buffer while the FSM idles.
                        if (buf_valid_q) begin
                            state_d     = START;
                            shift_d     = buf_q;
                            buf_valid_d = 1'b0;
                            bit_ctr_d   = '0;
                        end else if (accept) begin
                            state_d     = START;
                            shift_d     = data;
                            bit_ctr_d   = '0;
                            load_direct = 1'b1;
                        end
`endif
                    end else begin
                        gap_ctr_d = gap_ctr_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef SERIAL_TX_BUF_EN
        if (accept && !load_direct) begin
            buf_d       = data;
            buf_valid_d = 1'b1;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Line level. tx follows the current state one clock later, so the
    // start bit appears on the edge after acceptance.
    // ------------------------------------------------------------------
    always_comb begin
        tx_d = LINE_IDLE;
        case (state_q)
            START:   tx_d = LINE_START;
            DATA:    tx_d = shift_q[0];
            default: tx_d = LINE_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_ctr_q <= '0;
            gap_ctr_q <= '0;
            tx_q      <= LINE_IDLE;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_ctr_q <= bit_ctr_d;
            gap_ctr_q <= gap_ctr_d;
            tx_q      <= tx_d;
        end
    end

`ifdef SERIAL_TX_BUF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
        end
    end
`endif

endmodule : serial_tx
`default_nettype wire

// File: tb/tb_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_tx
//  Purpose  : Directed self-checking bench for serial_tx. One instance with
//             a short frame (4 clk/bit, 8 data bits, 2 gap bits) for shape,
//             handshake and reset checks, one at default geometry feeding a
//             behavioural line receiver for loopback.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_tx;

`ifdef SERIAL_TX_BUF_EN
    localparam bit BUF_ON = 1'b1;
`else
    localparam bit BUF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  a_data;
    logic        a_new;
    logic        a_ready;
    logic        a_tx;
    logic        a_busy;
    logic [31:0] b_data;
    logic        b_new;
    logic        b_ready;
    logic        b_tx;
    logic        b_busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_tx #(
        .CLK_PER_BIT (4),
        .PKT_LENGTH  (8),
        .GAP_BITS    (2)
    ) dut_a (
        .clk      (clk),
        .rst      (rst),
        .data     (a_data),
        .new_data (a_new),
        .ready    (a_ready),
        .tx       (a_tx),
        .busy     (a_busy)
    );

    serial_tx dut_b (
        .clk      (clk),
        .rst      (rst),
        .data     (b_data),
        .new_data (b_new),
        .ready    (b_ready),
        .tx       (b_tx),
        .busy     (b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level k edges after acceptance for the short frame.
    function automatic logic exp_tx(input logic [7:0] w, input int k);
        if (k >= 1 && k <= 4)  return 1'b1;
        if (k >= 5 && k <= 36) return w[(k - 5) / 4];
        return 1'b0;
    endfunction

    // Send one word on instance A and check every cycle of its frame.
    // poke > 0 raises new_data for one cycle at that offset mid-frame.
    task automatic send_and_check(input logic [7:0] w, input string tag, input int poke);
        chk({tag, "_ready_pre"}, {31'd0, a_ready}, 32'd1);
        a_data = w;
        a_new  = 1'b1;
        tick();
        a_new  = 1'b0;
        a_data = ~w;
        chk({tag, "_tx0"}, {31'd0, a_tx}, 32'd0);
        chk({tag, "_busy0"}, {31'd0, a_busy}, 32'd1);
        for (int k = 1; k <= 44; k++) begin
            if (poke > 0 && k == poke) a_new = 1'b1;
            tick();
            a_new = 1'b0;
            chk($sformatf("%s_tx%0d", tag, k), {31'd0, a_tx}, {31'd0, exp_tx(w, k)});
            chk($sformatf("%s_ready%0d", tag, k), {31'd0, a_ready},
                {31'd0, (BUF_ON || k >= 44)});
            chk($sformatf("%s_busy%0d", tag, k), {31'd0, a_busy}, {31'd0, (k < 44)});
        end
    endtask

    // Behavioural line receiver for instance B: sample mid-bit.
    logic [31:0] rx_words[$];
    logic [31:0] rx_w;
    initial begin : rx_model
        rx_w = '0;
        forever begin
            @(posedge clk);
            #2;
            if (b_tx === 1'b1) begin
                repeat (25) @(posedge clk);
                #2;
                for (int i = 0; i < 32; i++) begin
                    repeat (50) @(posedge clk);
                    #2;
                    rx_w[i] = b_tx;
                end
                rx_words.push_back(rx_w);
                repeat (25) @(posedge clk);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic        hist[0:99];
    logic [31:0] words[0:2];

    initial begin : stim
        int idx;
        int highs;
        int e2;
        logic acc;

        rst    = 1'b1;
        a_new  = 1'b0;
        a_data = '0;
        b_new  = 1'b0;
        b_data = '0;
        repeat (3) tick();
        chk("rst_a_tx",    {31'd0, a_tx},    32'd0);
        chk("rst_a_busy",  {31'd0, a_busy},  32'd0);
        chk("rst_a_ready", {31'd0, a_ready}, 32'd1);
        chk("rst_b_tx",    {31'd0, b_tx},    32'd0);
        chk("rst_b_ready", {31'd0, b_ready}, 32'd1);
        rst = 1'b0;
        tick();

        // Frame shape
        send_and_check(8'hA5, "a5", 0);
        repeat (3) tick();

        // Back-to-back with new_data held
        idx    = 0;
        a_data = 8'hFF;
        a_new  = 1'b1;
        for (int c = 0; c < 100; c++) begin
            acc = a_new && a_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx == 1) a_data = 8'h00;
                if (idx == 2) a_new = 1'b0;
            end
            hist[c] = a_tx;
        end
        e2 = BUF_ON ? 45 : 46;
        chk("b2b_accepts", idx, 32'd2);
        chk("b2b_tx0", {31'd0, hist[0]}, 32'd0);
        chk("b2b_rise1", {31'd0, hist[1]}, 32'd1);
        chk("b2b_lastbit", {31'd0, hist[36]}, 32'd1);
        highs = 0;
        for (int c = 37; c < e2; c++) if (hist[c]) highs++;
        chk("b2b_gap_highs", highs, 32'd0);
        chk("b2b_rise2", {31'd0, hist[e2]}, 32'd1);
        chk("b2b_start2_end", {31'd0, hist[e2 + 3]}, 32'd1);
        chk("b2b_data2_bit0", {31'd0, hist[e2 + 4]}, 32'd0);
        chk("b2b_idle_end", {31'd0, a_busy}, 32'd0);

`ifndef SERIAL_TX_BUF_EN
        // Word offered while busy is ignored
        send_and_check(8'h3C, "hs", 10);
        repeat (10) tick();
        chk("hs_no_frame_tx", {31'd0, a_tx}, 32'd0);
        chk("hs_no_frame_busy", {31'd0, a_busy}, 32'd0);
`endif

        // Reset during data bit 3 of 8'hFF
        a_data = 8'hFF;
        a_new  = 1'b1;
        tick();
        a_new = 1'b0;
        repeat (17) tick();
        chk("mid_bit3_tx", {31'd0, a_tx}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_tx",    {31'd0, a_tx},    32'd0);
        chk("mid_rst_busy",  {31'd0, a_busy},  32'd0);
        chk("mid_rst_ready", {31'd0, a_ready}, 32'd1);
        tick();
        send_and_check(8'h5A, "post", 0);

        // Loopback at default geometry
        words[0] = 32'hDEADBEEF;
        words[1] = 32'h00000001;
        words[2] = 32'h80000000;
        idx    = 0;
        b_data = words[0];
        b_new  = 1'b1;
        for (int c = 0; c < 7000 && (idx < 3 || b_busy); c++) begin
            acc = b_new && b_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx < 3) b_data = words[idx];
                else         b_new  = 1'b0;
            end
        end
        repeat (200) tick();
        chk("lb_accepts", idx, 32'd3);
        chk("lb_busy_end", {31'd0, b_busy}, 32'd0);
        chk("lb_frames", rx_words.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("lb_word%0d", i),
                (rx_words.size() > i) ? rx_words[i] : 32'hXXXXXXXX, words[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_tx
`default_nettype wire
